// File: rtl/plru_way_decoder_if.sv
// Bus bundle for plru_way_decoder: decode path, touch/lookup path and flush control.
// The master side (cache controller) drives requests, the slave side (decoder) answers.
interface plru_way_decoder_if #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 3
);
    localparam int WAY_BITS = $clog2(WAYS);

    logic                dec_en;
    logic [WAY_BITS-1:0] dec_sel;
    logic [WAYS-1:0]     dec_onehot;

    logic                touch_en;
    logic [SET_BITS-1:0] touch_set;
    logic [WAY_BITS-1:0] touch_way;

    logic [SET_BITS-1:0] lookup_set;
    logic [WAY_BITS-1:0] victim_way;
    logic [WAYS-1:0]     victim_onehot;

    logic                flush_req;
    logic                ready;

    modport master (
        output dec_en, dec_sel, touch_en, touch_set, touch_way, lookup_set, flush_req,
        input  dec_onehot, victim_way, victim_onehot, ready
    );

    modport slave (
        input  dec_en, dec_sel, touch_en, touch_set, touch_way, lookup_set, flush_req,
        output dec_onehot, victim_way, victim_onehot, ready
    );
endinterface

// File: rtl/plru_way_decoder.sv
// N-way way-select decoder with per-set tree pseudo-LRU and a sequential flush sweep.
// Optional macro PLRU_BYPASS_EN: forwards an accepted touch to a same-set lookup in
// the same cycle; without it the victim always comes from registered state.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | ready=1, touches accepted, flush_req starts a sweep
// ST_FLUSH | ready=0, clears set r_cnt each cycle, back to idle after last set
module plru_way_decoder #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 3
) (
    input logic              clk,
    input logic              rst,
    plru_way_decoder_if.slave bus
);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam int SETS     = 1 << SET_BITS;

    typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

    // Node n of the heap-numbered tree lives at bit n-1 (nodes 1..WAYS-1).
    logic [WAYS-2:0]     r_plru [SETS];
    state_t              r_state;
    state_t              w_next;
    logic [SET_BITS:0]   r_cnt;

    logic                w_ready;
    logic                w_cnt_last;
    logic                w_touch_fire;
    logic [WAYS-2:0]     w_touch_next;
    logic [WAYS-2:0]     w_lookup_bits;
    logic [WAY_BITS-1:0] w_victim_way;
    logic [WAYS-1:0]     w_dec_onehot;

    // Walk from the root: a 0 bit goes to the lower child, a 1 bit to the upper.
    // The leading 1 of the node index is shifted out on the final step, leaving the leaf.
    function automatic logic [WAY_BITS-1:0] f_victim(input logic [WAYS-2:0] bits);
        logic [WAYS-1:0]     t;
        logic [WAY_BITS-1:0] node;
        t    = {bits, 1'b0};
        node = WAY_BITS'(1);
        for (int l = 0; l < WAY_BITS; l++) begin
            node = (node << 1) | WAY_BITS'(t[node]);
        end
        return node;
    endfunction

    // Point every node on the path away from the touched way.
    function automatic logic [WAYS-2:0] f_touch(input logic [WAYS-2:0]     bits,
                                                input logic [WAY_BITS-1:0] way);
        logic [WAYS-1:0]     t;
        logic [WAY_BITS-1:0] node;
        logic [WAY_BITS-1:0] w;
        logic                d;
        t    = {bits, 1'b0};
        node = WAY_BITS'(1);
        w    = way;
        for (int l = 0; l < WAY_BITS; l++) begin
            d       = w[WAY_BITS-1];
            t[node] = ~d;
            node    = (node << 1) | WAY_BITS'(d);
            w       = w << 1;
        end
        return t[WAYS-1:1];
    endfunction

    // Decode path: pure combinational one-hot gated by dec_en.
    always_comb begin
        w_dec_onehot = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_dec_onehot[i] = bus.dec_en && (bus.dec_sel == WAY_BITS'(i));
        end
    end

    // Flush request in the same cycle drops the touch.
    assign w_touch_fire = bus.touch_en && w_ready && !bus.flush_req;
    assign w_touch_next = f_touch(r_plru[bus.touch_set], bus.touch_way);
    assign w_cnt_last   = (r_cnt == (SET_BITS+1)'(SETS - 1));

`ifdef PLRU_BYPASS_EN
    assign w_lookup_bits = (w_touch_fire && (bus.lookup_set == bus.touch_set))
                         ? w_touch_next : r_plru[bus.lookup_set];
`else
    assign w_lookup_bits = r_plru[bus.lookup_set];
`endif

    assign w_victim_way = f_victim(w_lookup_bits);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.flush_req) w_next = ST_FLUSH;
            ST_FLUSH: if (w_cnt_last)    w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE:  w_ready = 1'b1;
            ST_FLUSH: w_ready = 1'b0;
            default:  w_ready = 1'b0;
        endcase
    end

    // Sweep counter: zeroed on flush start, one step per swept set; the extra MSB
    // keeps it from wrapping before the terminal compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        r_cnt <= '0;
        else if (r_state == ST_IDLE && bus.flush_req)   r_cnt <= '0;
        else if (r_state == ST_FLUSH)                   r_cnt <= r_cnt + 1'b1;
    end

    // PLRU storage: sweep clear takes precedence, touches only land while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_plru[r_cnt[SET_BITS-1:0]] <= '0;
        end else if (w_touch_fire) begin
            r_plru[bus.touch_set] <= w_touch_next;
        end
    end

    assign bus.dec_onehot    = w_dec_onehot;
    assign bus.victim_way    = w_victim_way;
    assign bus.victim_onehot = WAYS'(1) << w_victim_way;
    assign bus.ready         = w_ready;
endmodule
